// File: rtl/rr_arb4_bus_ctrl.sv
// Four-slot round-robin arbiter feeding one registered valid/ready result bus.
// Optional: define ARB_TIMEOUT_EN to drop a grant stalled TIMEOUT cycles and raise timeout_err.
module rr_arb4_bus_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic [3:0]       ack,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arb4_bus_ctrl: TIMEOUT must lie in 2..255");
    end

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_out_src;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_out_data;

    logic             w_xfer;
    logic             w_load;
    logic             w_drop;
    logic             w_ptr_upd;
    logic             w_timeout;
    logic [3:0]       w_grant_oh;
    logic [3:0]       w_mask_req;
    logic [1:0]       w_next_ptr;
    logic [1:0]       w_start;
    logic             w_pick_found;
    logic [1:0]       w_pick_idx;
    logic [WIDTH-1:0] w_pick_data;

    // Returns {found, index}; the lowest offset from start wins.
    function automatic logic [2:0] f_pick(input logic [3:0] rq, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (rq[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_xfer     = r_out_valid & out_ready;
    assign w_grant_oh = 4'b0001 << r_out_src;
    assign w_next_ptr = r_out_src + 2'd1;

    // In HOLD the pick is the back-to-back successor: grantee masked, search after it.
    assign w_mask_req = (r_state == HOLD) ? (req & ~w_grant_oh) : req;
    assign w_start    = (r_state == HOLD) ? w_next_ptr : r_ptr;
    assign {w_pick_found, w_pick_idx} = f_pick(w_mask_req, w_start);

    always_comb begin
        w_pick_data = data0;
        case (w_pick_idx)
            2'd0:    w_pick_data = data0;
            2'd1:    w_pick_data = data1;
            2'd2:    w_pick_data = data2;
            default: w_pick_data = data3;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] LP_STALL_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_stall;
    logic       r_timeout_err;

    assign w_timeout   = (r_state == HOLD) && !out_ready && (r_stall == LP_STALL_LAST);
    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_load    = ((r_state == IDLE) | w_xfer) & w_pick_found;
    assign w_drop    = (w_xfer & ~w_pick_found) | w_timeout;
    assign w_ptr_upd = w_xfer | w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 2'd0;
            r_busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_stall       <= 8'd0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_state     <= HOLD;
                r_out_valid <= 1'b1;
                r_busy      <= 1'b1;
                r_out_src   <= w_pick_idx;
                r_out_data  <= w_pick_data;
            end else if (w_drop) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end
            if (w_ptr_upd) r_ptr <= w_next_ptr;
`ifdef ARB_TIMEOUT_EN
            if (w_load || w_xfer)
                r_stall <= 8'd0;
            else if (r_state == HOLD && !out_ready && !w_timeout)
                r_stall <= r_stall + 8'd1;
            if (w_timeout) r_timeout_err <= 1'b1;
`endif
        end
    end

    // ack is combinational so the winner sees it in the transfer cycle itself.
    assign ack       = w_xfer ? w_grant_oh : 4'b0000;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rr_arb4_bus_ctrl.sv
// Directed bench for rr_arb4_bus_ctrl: expected grants queued at stimulus time, popped on each transfer.
module tb_rr_arb4_bus_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic [WIDTH-1:0] data0 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic [WIDTH-1:0] data2 = '0;
    logic [WIDTH-1:0] data3 = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic [3:0]       ack;
    logic             busy;
    logic             timeout_err;

    typedef struct packed {
        logic [1:0]       src;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] last_ack = 4'b0000;

    rr_arb4_bus_ctrl #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s);
        exp_t e;
        e.src = s;
        case (s)
            2'd0:    e.data = data0;
            2'd1:    e.data = data1;
            2'd2:    e.data = data2;
            default: e.data = data3;
        endcase
        sb_q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Sample on the falling edge; every transfer is matched against the queue head.
    task automatic smp();
        exp_t e;
        @(negedge clk);
        last_ack = ack;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer", 32'(ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_src", 32'(out_src), 32'(e.src));
                check("sb_data", out_data, e.data);
                check("sb_ack", 32'(ack), 32'(4'b0001 << e.src));
            end
        end else begin
            check("no_xfer_ack", 32'(ack), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        data0 = 32'hA000_0000;
        data1 = 32'hA111_1111;
        data2 = 32'hA222_2222;
        data3 = 32'hA333_3333;

        // Reset asserted between edges must clear outputs at once.
        #12;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp();
            check("idle_valid", 32'(out_valid), 32'd0);
            adv();
        end

        // Single request, ready already high; leaves ptr at 3.
        data2     = 32'hDEAD_BEEF;
        req       = 4'b0100;
        out_ready = 1'b1;
        push(2'd2);
        smp();
        check("single_latency", 32'(out_valid), 32'd0);
        adv();
        smp();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        adv();
        req = 4'b0000;
        smp();
        check("single_done_valid", 32'(out_valid), 32'd0);
        check("single_done_busy", 32'(busy), 32'd0);
        check("single_q", 32'(sb_q.size()), 32'd0);
        adv();

        // Full contention from ptr=3: 3,0,1,2,3 with no bubble.
        req = 4'b1111;
        push(2'd3); push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        smp();
        check("wrap_latency", 32'(out_valid), 32'd0);
        adv();
        for (int k = 0; k < 5; k++) begin
            smp();
            check("wrap_valid", 32'(out_valid), 32'd1);
            adv();
            if (k == 3) req = 4'b1000;
            if (k == 4) req = 4'b0000;
        end
        smp();
        check("wrap_idle", 32'(out_valid), 32'd0);
        check("wrap_q", 32'(sb_q.size()), 32'd0);
        adv();

        // Each requester drops after its ack: 0,1,2,3 back-to-back from ptr=0.
        req = 4'b1111;
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        smp();
        adv();
        for (int k = 0; k < 4; k++) begin
            smp();
            check("rr_valid", 32'(out_valid), 32'd1);
            adv();
            req = req & ~last_ack;
        end
        smp();
        check("rr_idle", 32'(out_valid), 32'd0);
        check("rr_q", 32'(sb_q.size()), 32'd0);
        adv();

        // Backpressure on slot 1 while its data changes and slots 0/3 start requesting.
        out_ready = 1'b0;
        req       = 4'b0010;
        data1     = 32'h1111_1111;
        push(2'd1);
        smp();
        adv();
        req = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            data1 = 32'h5555_0000 + 32'(k);
            smp();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_src", 32'(out_src), 32'd1);
            check("bp_data", out_data, 32'h1111_1111);
            check("bp_busy", 32'(busy), 32'd1);
            adv();
        end
        out_ready = 1'b1;
        push(2'd3); push(2'd0);
        smp();
        adv();
        req = 4'b1001;
        smp();
        adv();
        req = 4'b0001;
        smp();
        adv();
        req = 4'b0000;
        smp();
        check("bp_idle", 32'(out_valid), 32'd0);
        check("bp_q", 32'(sb_q.size()), 32'd0);
        adv();

        // Reset during HOLD (ptr=1): grant vanishes without ack, ptr returns to 0.
        out_ready = 1'b0;
        req       = 4'b0100;
        smp();
        adv();
        smp();
        check("mid_hold_valid", 32'(out_valid), 32'd1);
        check("mid_hold_src", 32'(out_src), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_src", 32'(out_src), 32'd0);
        adv();
        rst_n     = 1'b1;
        req       = 4'b1001;
        out_ready = 1'b1;
        push(2'd0); push(2'd3);
        smp();
        adv();
        smp();
        adv();
        req = 4'b1000;
        smp();
        adv();
        req = 4'b0000;
        smp();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        check("post_rst_q", 32'(sb_q.size()), 32'd0);
        check("final_timeout_err", 32'(timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
